div_restoring_smm129: RTL and testbench

//  Sequential radix-2 restoring divider: splits a 2W-bit product-width dividend by a W-bit divisor into
//  a 2W-bit quotient and W-bit remainder. Inverse of the W x W Karatsuba multipliers; sits after them
//  for reduction/consistency checks in the modular datapath. One quotient bit per clock, valid/ready both ends.

---
 rtl/div_restoring_smm129_pkg.sv | 17 +
 rtl/div_restoring_smm129_step.sv | 25 ++
 rtl/div_restoring_smm129.sv | 130 +++++++++++++
 tb/tb_div_restoring_smm129.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_restoring_smm129_pkg.sv
// Shared widths and state encoding for the restoring divider.
package div_restoring_smm129_pkg;

  localparam int unsigned W     = 129;
  localparam int unsigned W2    = 2 * W;
  localparam int unsigned CNT_W = 9;

  // Counter value seen on the edge that performs the final quotient step.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_restoring_smm129_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module div_step_smm
  import div_restoring_smm129_pkg::*;
(
  input  logic [W:0]   r_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] d_i,
  output logic [W:0]   r_o,
  output logic         bit_o
);

  logic [W+1:0] t;
  logic [W:0]   diff;

  // Trial subtraction; r_i never exceeds D-1 so the top bit of t is only a
  // safety margin for the compare and never reaches r_o.
  always_comb begin
    t     = {r_i, q_msb_i};
    diff  = t[W:0] - {1'b0, d_i};
    bit_o = (t >= {2'b00, d_i});
    r_o   = bit_o ? diff : t[W:0];
  end

endmodule

// File: rtl/div_restoring_smm129.sv
// Sequential radix-2 restoring divider, 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for operands, in_ready high
//  RUN     | one restoring step per cycle, 2W cycles total
//  DONE    | result held on the outputs until out_ready
module div_restoring_smm129
  import div_restoring_smm129_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W2-1:0] dividend,
  input  logic [W-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W2-1:0] quotient,
  output logic [W-1:0]  remainder,
  output logic          div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      q_q, q_d;
  logic [W:0]         r_q, r_d;
  logic [W-1:0]       d_q, d_d;
  logic [W2-1:0]      quotient_q, quotient_d;
  logic [W-1:0]       remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               last_step;
  logic [W:0]         step_r;
  logic               step_bit;

  div_step_smm u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[W2-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .bit_o   (step_bit)
  );

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign last_step = (cnt_q == LAST_CNT);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Next-state logic; a zero divisor skips RUN and goes straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: operand capture, shift/subtract steps, result capture.
  always_comb begin
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          d_d   = divisor;
          q_d   = dividend;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend[W-1:0];
            dbz_d       = 1'b1;
          end
        end
      end
      ST_RUN: begin
        q_d   = {q_q[W2-2:0], step_bit};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          quotient_d  = {q_q[W2-2:0], step_bit};
          remainder_d = step_r[W-1:0];
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decode directly from state; results come from registers.
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_div_restoring_smm129.sv
// Self-checking bench for div_restoring_smm129: directed corner cases plus
// random operands compared with plain arithmetic division.
module tb_div_restoring_smm129;
  import div_restoring_smm129_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W2-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [W2-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_errs   = 0;

  div_restoring_smm129 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W2-1:0] rand_wide();
    logic [W2-1:0] x = '0;
    for (int i = 0; i < 9; i++) x = {x[W2-33:0], 32'($urandom())};
    return x;
  endfunction

  // One complete operation: offer, measure latency, compare against the
  // arithmetic reference, optionally stall in DONE, then consume.
  task automatic do_op(input logic [W2-1:0] dd, input logic [W-1:0] dv,
                       input string tag, input int hold);
    int              edges;
    logic [W2-1:0]   exp_q;
    logic [W-1:0]    exp_r;
    logic            exp_z;
    int              exp_lat;
    logic [2*W2-1:0] recon;
    logic [W2-1:0]   snap_q;
    logic [W-1:0]    snap_r;

    if (dv == '0) begin
      exp_q   = '1;
      exp_r   = dd[W-1:0];
      exp_z   = 1'b1;
      exp_lat = 1;
    end else begin
      exp_q   = dd / {{W{1'b0}}, dv};
      exp_r   = W'(dd % {{W{1'b0}}, dv});
      exp_z   = 1'b0;
      exp_lat = W2 + 1;
    end

    @(negedge clk);
    check({tag, ".in_ready_idle"}, W2'(in_ready), W2'(1));
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = rand_wide();
    divisor  = W'(rand_wide());
    while (!out_valid && edges < 600) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, ".latency"}, W2'(edges), W2'(exp_lat));
    check({tag, ".quotient"}, quotient, exp_q);
    check({tag, ".remainder"}, W2'(remainder), W2'(exp_r));
    check({tag, ".div_by_zero"}, W2'(div_by_zero), W2'(exp_z));
    if (dv != '0) begin
      recon = (2*W2)'(quotient) * (2*W2)'(dv) + (2*W2)'(remainder);
      check({tag, ".identity"}, W2'(recon == (2*W2)'(dd)), W2'(1));
      check({tag, ".rem_lt_div"}, W2'(remainder < dv), W2'(1));
    end

    snap_q = quotient;
    snap_r = remainder;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = rand_wide();
      divisor  = W'(rand_wide());
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, W2'(out_valid), W2'(1));
      check({tag, ".hold_in_ready"}, W2'(in_ready), W2'(0));
      check({tag, ".hold_quotient"}, quotient, snap_q);
      check({tag, ".hold_remainder"}, W2'(remainder), W2'(snap_r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".consumed_in_ready"}, W2'(in_ready), W2'(1));
    check({tag, ".consumed_out_valid"}, W2'(out_valid), W2'(0));
  endtask

  initial begin
    logic [W2-1:0] big;
    logic [W-1:0]  dmax;
    logic [W2-1:0] rd;
    logic [W-1:0]  rv;
    int            edges;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.in_ready", W2'(in_ready), W2'(1));
    check("reset.out_valid", W2'(out_valid), W2'(0));
    check("reset.quotient", quotient, '0);
    check("reset.remainder", W2'(remainder), '0);
    check("reset.div_by_zero", W2'(div_by_zero), '0);

    do_op(W2'(100), W'(7), "t1_100_7", 0);

    dmax = '1;
    big  = W2'(dmax) * W2'(dmax);
    do_op(big, dmax, "t2_max_sq", 0);

    do_op(W2'(5), W'(9), "t3_small", 0);
    big = '1;
    do_op(big, W'(1), "t3_div1", 0);

    do_op(W2'(20'h1_2345), W'(0), "t4_dbz", 0);

    do_op(W2'(1000), W'(3), "t5_stall", 10);

    // Reset in the middle of RUN must abort without leaving a result.
    @(negedge clk);
    dividend = W2'(12345);
    divisor  = W'(11);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst.out_valid", W2'(out_valid), W2'(0));
    check("t6_rst.in_ready", W2'(in_ready), W2'(1));
    check("t6_rst.quotient", quotient, '0);
    check("t6_rst.remainder", W2'(remainder), '0);
    check("t6_rst.div_by_zero", W2'(div_by_zero), '0);
    do_op(W2'(100), W'(7), "t6_after", 0);

    for (int k = 0; k < 50; k++) begin
      rd = rand_wide() >> $urandom_range(0, W2 - 1);
      rv = W'(rand_wide()) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 9) == 0) rv = '0;
      do_op(rd, rv, $sformatf("rand%0d", k), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
